// File: rtl/adder_64b_mod_pkg.sv
// Shared constants for the ALU adder/subtractor core.
// SUB encoding is fixed here so every consumer agrees on add vs. subtract.
package adder_64b_mod_pkg;

  localparam int WIDTH = 64;
  localparam int GROUP_W = 4;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/adder_64b_mod_if.sv
// Operand/result bundle between the ALU control and the adder core.
// No handshake: A/B/SUB are sampled on every rising edge and S/COUT show the
// result of the previous edge's operands; there is no valid or ready.
interface adder_64b_mod_if
  import adder_64b_mod_pkg::*;
#(
  parameter int WIDTH = adder_64b_mod_pkg::WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic [WIDTH-1:0] S;
  logic             COUT;

  modport master (output A, output B, output SUB, input S, input COUT);
  modport slave  (input A, input B, input SUB, output S, output COUT);

endinterface

// File: rtl/adder_64b_mod_cla_4b.sv
// 4-bit carry-lookahead slice: internal carries are flattened generate/propagate
// terms, and group P/G are exported for the group-level carry relation.
module cla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       P,
  output logic       G
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & cin);

  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
             (p[3] & p[2] & p[1] & g[0]);

  assign cout = G | (P & cin);
  assign s    = p ^ c;

endmodule

// File: rtl/adder_64b_mod.sv
// Two's-complement adder/subtractor: XOR-inverted B with carry-in = SUB, a ripple
// of 4-bit lookahead groups, and a single registered {COUT, S} stage.
module adder_64b_mod
  import adder_64b_mod_pkg::*;
#(
  parameter int WIDTH = adder_64b_mod_pkg::WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  adder_64b_mod_if.slave  bus
);

  // WIDTH must be a multiple of the group width.
  localparam int NGRP = WIDTH / GROUP_W;

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [NGRP:0]    carry;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_g;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  assign sub_mode = (bus.SUB == ALU_SUB);
  assign b_eff    = bus.B ^ {WIDTH{sub_mode}};
  assign carry[0] = sub_mode;

  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    cla_4b u_cla (
      .a    (bus.A[i*GROUP_W +: GROUP_W]),
      .b    (b_eff[i*GROUP_W +: GROUP_W]),
      .cin  (carry[i]),
      .s    (sum[i*GROUP_W +: GROUP_W]),
      .cout (carry[i+1]),
      .P    (grp_p[i]),
      .G    (grp_g[i])
    );

    // The rippled carry must agree with the group lookahead relation.
    a_grp_carry: assert property (@(posedge clk) disable iff (reset)
      carry[i+1] == (grp_g[i] | (grp_p[i] & carry[i])));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum;
      cout_q <= carry[NGRP];
    end
  end

  assign bus.S    = s_q;
  assign bus.COUT = cout_q;

endmodule

// File: tb/tb_adder_64b_mod.sv
// Self-checking bench for adder_64b_mod: directed corner cases, reset behaviour,
// alternating add/sub pipelining and random vectors against an arithmetic model.
module tb_adder_64b_mod;

  localparam int W = 64;

  logic clk;
  logic reset;

  adder_64b_mod_if bus ();

  adder_64b_mod dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {COUT,S}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Add: plain 65-bit sum. Sub: difference mod 2^64, COUT = no borrow (A >= B).
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W-1:0] d;
    if (!sub) return {1'b0, a} + {1'b0, b};
    d = a - b;
    return {(a >= b), d};
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Apply operands at the falling edge, check one cycle later just after the rise.
  task automatic drive_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
    logic [W:0] exp;
    @(negedge clk);
    bus.A   = a;
    bus.B   = b;
    bus.SUB = sub;
    exp_q.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, {bus.COUT, bus.S}, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    bus.A   = rand64();
    bus.B   = rand64();
    bus.SUB = 1'b0;

    #1;
    check("reset_t0", {bus.COUT, bus.S}, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.A   = rand64();
      bus.B   = rand64();
      bus.SUB = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      check("reset_hold", {bus.COUT, bus.S}, '0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    drive_op("add_5_3",       64'd5,      64'd3,      1'b0);
    drive_op("sub_5_3",       64'd5,      64'd3,      1'b1);
    drive_op("sub_equal",     64'h1234,   64'h1234,   1'b1);
    drive_op("sub_borrow",    64'd3,      64'd5,      1'b1);
    drive_op("wrap_ones_1",   {W{1'b1}},  64'd1,      1'b0);
    drive_op("wrap_msb",      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    drive_op("sub_zero_one",  64'd0,      64'd1,      1'b1);
    drive_op("sub_zero_zero", 64'd0,      64'd0,      1'b1);
    drive_op("add_ones_ones", {W{1'b1}},  {W{1'b1}},  1'b0);

    // Async reset mid-cycle: outputs clear without an edge, in-flight result discarded
    drive_op("pre_async", 64'd5, 64'd3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_clear", {bus.COUT, bus.S}, '0);
    @(negedge clk);
    bus.A   = rand64();
    bus.B   = rand64();
    bus.SUB = 1'b1;
    @(posedge clk);
    #1;
    check("reset_over_edge", {bus.COUT, bus.S}, '0);
    @(negedge clk);
    reset = 1'b0;
    drive_op("first_after_reset", 64'd100, 64'd58, 1'b1);

    // Back-to-back add/sub alternation
    for (int i = 0; i < 64; i++) begin
      drive_op("alt", rand64(), rand64(), i[0]);
    end

    // Random vectors, occasionally with equal operands or extremes
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = rand64();
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       b = {W{1'b1}};
        2:       b = 64'd1;
        default: b = rand64();
      endcase
      drive_op("rand", a, b, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
